// File: rtl/fft_axis_master_if_pkg.sv
// Shared constants and types for the FFT AXI4-Stream output path.
// Default widths, FIFO sizing and the transmit FSM state encoding.
package axi_stream_pckg;

  localparam int VLW_WDT           = 64;
  localparam int M_TDATA_WDT       = 32;
  localparam int M_FIFO_SIZE       = 16;
  localparam int M_FIFO_ADDR_WDT   = $clog2(M_FIFO_SIZE);
  localparam int C_FFT_SIZE_LOG2   = 12;
  localparam int FFT_MEM_SIZE      = 1 << C_FFT_SIZE_LOG2;
  localparam int OUTPUT_MEM_OFFSET = 0;
  localparam int M_IF_BUFFER_SIZE  = VLW_WDT / M_TDATA_WDT;
  localparam int M_PACKET_CNT      = FFT_MEM_SIZE * M_IF_BUFFER_SIZE;
  localparam int M_FIFO_WR_FINAL   = (M_PACKET_CNT - 1) % M_FIFO_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } m_if_state_t;

endpackage

// File: rtl/fft_axis_master_if_fifo.sv
// Synchronous first-word-fall-through FIFO, async active-high reset.
// Ports: push/push_data in, pop in, head out (current entry), full/empty/count.
module axis_sync_fifo #(
  parameter int WDT   = 33,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WDT-1:0]         push_data,
  input  logic                   pop,
  output logic [WDT-1:0]         head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WDT-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_axis_master_if.sv
// FFT result streamer: reads frame words, splits into beats, AXIS master.
// Ports: start/busy/done control, mem_rd_* read port, m_axis_* stream.
module fft_axis_master_if #(
  parameter int VLW_WDT           = axi_stream_pckg::VLW_WDT,
  parameter int M_TDATA_WDT       = axi_stream_pckg::M_TDATA_WDT,
  parameter int M_FIFO_SIZE       = axi_stream_pckg::M_FIFO_SIZE,
  parameter int C_FFT_SIZE_LOG2   = axi_stream_pckg::C_FFT_SIZE_LOG2,
  parameter int OUTPUT_MEM_OFFSET = axi_stream_pckg::OUTPUT_MEM_OFFSET
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_rd_en,
  output logic [C_FFT_SIZE_LOG2-1:0] mem_rd_addr,
  input  logic [VLW_WDT-1:0]         mem_rd_data,
  output logic [M_TDATA_WDT-1:0]     m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
);

  import axi_stream_pckg::*;

  localparam int BEATS = VLW_WDT / M_TDATA_WDT;
  localparam int PKT   = (1 << C_FFT_SIZE_LOG2) * BEATS;
  localparam int CW    = C_FFT_SIZE_LOG2 + $clog2(BEATS);
  localparam int AW    = $clog2(M_FIFO_SIZE);
  localparam int SW    = $clog2(BEATS) + 1;
  localparam int LW    = C_FFT_SIZE_LOG2;

  localparam logic [CW-1:0] LAST_BEAT = CW'(PKT - 1);
  localparam logic [LW-1:0] LAST_WORD = '1;
  localparam logic [LW-1:0] ADDR_BASE = LW'(OUTPUT_MEM_OFFSET);

  m_if_state_t state, state_nx;

  logic [LW-1:0]          rd_idx;
  logic                   rd_vld;
  logic [VLW_WDT-1:0]     sreg;
  logic [SW-1:0]          ser_left;
  logic [CW-1:0]          push_cnt;
  logic [CW-1:0]          beat_cnt;
  logic                   issue;
  logic                   can_issue;
  logic                   hs;
  logic                   frame_end;
  logic                   push;
  logic [M_TDATA_WDT:0]   push_data;
  logic [M_TDATA_WDT:0]   head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [AW:0]            fifo_count;
  int                     ser_pend;
  int                     pend;
  int                     free_slots;

  // Serializer: first beat goes straight from the memory bus,
  // the rest come from the shift register, MS half first.
  assign push = rd_vld || (ser_left != '0);
  assign push_data = {
    rd_vld ? mem_rd_data[VLW_WDT-1 -: M_TDATA_WDT]
           : sreg[VLW_WDT-1 -: M_TDATA_WDT],
    push_cnt == LAST_BEAT
  };

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = head[M_TDATA_WDT:1];
  assign m_axis_tlast  = head[0] && !fifo_empty;
  assign hs            = m_axis_tvalid && m_axis_tready;
  assign frame_end     = hs && (beat_cnt == LAST_BEAT);
  assign busy          = state != IDLE;

  // Credit check: beats still to land in the FIFO are the read in
  // flight plus what the serializer holds (incl. this cycle's push).
  // The serializer must also be idle by the time new data returns.
  always_comb begin
    ser_pend   = rd_vld ? BEATS : int'(ser_left);
    pend       = ser_pend + (mem_rd_en ? BEATS : 0);
    free_slots = M_FIFO_SIZE - int'(fifo_count);
    can_issue  = !mem_rd_en && !fifo_full && (ser_pend <= 2) &&
                 ((free_slots - pend) >= BEATS);
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          issue    = can_issue;
          state_nx = (issue && rd_idx == LAST_WORD) ? DRAIN : READ;
        end
      end
      READ: begin
        issue = can_issue;
        if (issue && rd_idx == LAST_WORD) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_end) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      rd_idx      <= '0;
      rd_vld      <= 1'b0;
      sreg        <= '0;
      ser_left    <= '0;
      push_cnt    <= '0;
      beat_cnt    <= '0;
      done        <= 1'b0;
    end else begin
      mem_rd_en <= issue;
      rd_vld    <= mem_rd_en;
      done      <= frame_end;
      if (issue) begin
        mem_rd_addr <= ADDR_BASE + rd_idx;
        rd_idx      <= rd_idx + LW'(1);
      end
      if (rd_vld) begin
        sreg     <= mem_rd_data << M_TDATA_WDT;
        ser_left <= SW'(BEATS - 1);
      end else if (ser_left != '0) begin
        sreg     <= sreg << M_TDATA_WDT;
        ser_left <= ser_left - SW'(1);
      end
      if (push) begin
        push_cnt <= push_cnt + CW'(1);
      end
      if (hs) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

  axis_sync_fifo #(
    .WDT   (M_TDATA_WDT + 1),
    .DEPTH (M_FIFO_SIZE)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (hs),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fft_axis_master_if.sv
// Directed bench for fft_axis_master_if: 8-word and default-size frames.
// Memory model returns {i, ~i} one cycle after each read strobe.
module tb_fft_axis_master_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start_s, busy_s, done_s, rd_en_s;
  logic [2:0]  addr_s;
  logic [63:0] rdata_s;
  logic [31:0] tdata_s;
  logic        tvalid_s, tready_s, tlast_s;

  logic        start_d, busy_d, done_d, rd_en_d;
  logic [11:0] addr_d;
  logic [63:0] rdata_d;
  logic [31:0] tdata_d;
  logic        tvalid_d, tready_d, tlast_d;

  int checks = 0;
  int failures = 0;

  fft_axis_master_if #(.C_FFT_SIZE_LOG2(3)) u_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s),
    .done(done_s), .mem_rd_en(rd_en_s), .mem_rd_addr(addr_s),
    .mem_rd_data(rdata_s), .m_axis_tdata(tdata_s),
    .m_axis_tvalid(tvalid_s), .m_axis_tready(tready_s),
    .m_axis_tlast(tlast_s)
  );

  fft_axis_master_if u_d (
    .clk(clk), .rst(rst), .start(start_d), .busy(busy_d),
    .done(done_d), .mem_rd_en(rd_en_d), .mem_rd_addr(addr_d),
    .mem_rd_data(rdata_d), .m_axis_tdata(tdata_d),
    .m_axis_tvalid(tvalid_d), .m_axis_tready(tready_d),
    .m_axis_tlast(tlast_d)
  );

  always @(posedge clk) begin
    rdata_s <= rd_en_s ? {32'(addr_s), ~32'(addr_s)} : {2{32'hDEADBEEF}};
    rdata_d <= rd_en_d ? {32'(addr_d), ~32'(addr_d)} : {2{32'hDEADBEEF}};
  end

  logic [32:0] beats[$];
  time         bt[$];
  time         done_t[$];
  int          rd_cnt;
  bit          addr_bad, stab_bad, ovf;
  logic        pv;
  logic [32:0] pbeat;

  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0;
      pv = 1'b0;
    end else begin
      if (rd_en_s) begin
        if (addr_s !== 3'(rd_cnt)) addr_bad = 1'b1;
        rd_cnt++;
      end
      if (u_s.fifo_count > 5'd16) ovf = 1'b1;
      if (pv && (!tvalid_s || {tdata_s, tlast_s} !== pbeat)) stab_bad = 1'b1;
      pv = tvalid_s && !tready_s;
      pbeat = {tdata_s, tlast_s};
      if (tvalid_s && tready_s) begin
        beats.push_back({tdata_s, tlast_s});
        bt.push_back($time);
      end
      if (done_s) done_t.push_back($time);
    end
  end

  int          bd_cnt, bd_err, bd_done;
  logic [31:0] bd_exp;

  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid_d && tready_d) begin
        bd_exp = (bd_cnt % 2 == 0) ? 32'(bd_cnt / 2) : ~32'(bd_cnt / 2);
        if (tdata_d !== bd_exp || tlast_d !== (bd_cnt == 8191)) bd_err++;
        bd_cnt++;
      end
      if (done_d) bd_done++;
    end
  end

  function automatic logic [32:0] exp_beat(int k);
    logic [31:0] w;
    w = 32'(k / 2);
    return {(k % 2 == 0) ? w : ~w, k == 15};
  endfunction

  task automatic clear_log();
    beats.delete();
    bt.delete();
    done_t.delete();
    rd_cnt = 0;
    addr_bad = 1'b0;
    stab_bad = 1'b0;
    ovf = 1'b0;
  endtask

  task automatic pulse_start_s(output time ts);
    @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk);
    ts = $time;
    #1 start_s = 1'b0;
  endtask

  task automatic wait_done_s(input int n, input int budget);
    for (int i = 0; i < budget && done_t.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    start_s = 0; tready_s = 0; start_d = 0; tready_d = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_s); end
    checks++; if (done_s !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_s); end
    checks++; if (rd_en_s !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en_s); end
    checks++; if (addr_s !== 3'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr_s); end
    checks++; if (tvalid_s !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", tvalid_s); end
    checks++; if (tlast_s !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", tlast_s); end
    checks++; if (tdata_s !== 32'd0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", tdata_s); end
    checks++; if (tvalid_d !== 1'b0 || busy_d !== 1'b0) begin
      failures++; $display("FAIL reset_dflt got=%b%b exp=00", tvalid_d, busy_d);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    time ts;
    clear_log();
    tready_s = 1'b1;
    pulse_start_s(ts);
    checks++; if (busy_s !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy_s); end
    wait_done_s(1, 200);
    repeat (5) @(negedge clk);
    checks++; if (done_t.size() != 1) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=1", done_t.size()); end
    checks++; if (beats.size() != 16) begin failures++; $display("FAIL basic_beat_cnt got=%0d exp=16", beats.size()); end
    for (int k = 0; k < beats.size() && k < 16; k++) begin
      checks++;
      if (beats[k] !== exp_beat(k)) begin
        failures++; $display("FAIL basic_beat%0d got=%h exp=%h", k, beats[k], exp_beat(k));
      end
    end
    if (beats.size() == 16 && done_t.size() == 1) begin
      checks++; if (bt[0] - ts > 45) begin failures++; $display("FAIL basic_latency got=%0t exp<=45", bt[0] - ts); end
      checks++; if (bt[15] - bt[0] != 150) begin failures++; $display("FAIL basic_rate got=%0t exp=150", bt[15] - bt[0]); end
      checks++; if (done_t[0] - bt[15] != 10) begin failures++; $display("FAIL basic_done_time got=%0t exp=10", done_t[0] - bt[15]); end
    end
    checks++; if (rd_cnt != 8 || addr_bad) begin failures++; $display("FAIL basic_reads got=%0d/%b exp=8/0", rd_cnt, addr_bad); end
    checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy_s); end
  endtask

  task automatic test_random_stall();
    time ts;
    clear_log();
    tready_s = 1'b0;
    pulse_start_s(ts);
    for (int i = 0; i < 600 && done_t.size() < 1; i++) begin
      @(posedge clk);
      #1 tready_s = ($urandom_range(0, 9) < 3);
    end
    tready_s = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done_t.size() != 1) begin failures++; $display("FAIL rand_done got=%0d exp=1", done_t.size()); end
    checks++; if (beats.size() != 16) begin failures++; $display("FAIL rand_beat_cnt got=%0d exp=16", beats.size()); end
    for (int k = 0; k < beats.size() && k < 16; k++) begin
      checks++;
      if (beats[k] !== exp_beat(k)) begin
        failures++; $display("FAIL rand_beat%0d got=%h exp=%h", k, beats[k], exp_beat(k));
      end
    end
    checks++; if (stab_bad) begin failures++; $display("FAIL rand_stable got=1 exp=0"); end
    checks++; if (ovf) begin failures++; $display("FAIL rand_overflow got=1 exp=0"); end
    checks++; if (rd_cnt != 8 || addr_bad) begin failures++; $display("FAIL rand_reads got=%0d/%b exp=8/0", rd_cnt, addr_bad); end
  endtask

  task automatic test_stall();
    time ts;
    clear_log();
    tready_s = 1'b0;
    pulse_start_s(ts);
    repeat (40) @(posedge clk);
    #1;
    checks++; if (u_s.fifo_count !== 5'd16) begin failures++; $display("FAIL stall_fill got=%0d exp=16", u_s.fifo_count); end
    checks++; if (rd_en_s !== 1'b0) begin failures++; $display("FAIL stall_rd_en got=%b exp=0", rd_en_s); end
    checks++; if (tvalid_s !== 1'b1) begin failures++; $display("FAIL stall_tvalid got=%b exp=1", tvalid_s); end
    checks++; if ({tdata_s, tlast_s} !== exp_beat(0)) begin
      failures++; $display("FAIL stall_head got=%h exp=%h", {tdata_s, tlast_s}, exp_beat(0));
    end
    checks++; if (rd_cnt != 8) begin failures++; $display("FAIL stall_reads got=%0d exp=8", rd_cnt); end
    tready_s = 1'b1;
    wait_done_s(1, 200);
    checks++; if (beats.size() != 16) begin failures++; $display("FAIL stall_beat_cnt got=%0d exp=16", beats.size()); end
    for (int k = 0; k < beats.size() && k < 16; k++) begin
      checks++;
      if (beats[k] !== exp_beat(k)) begin
        failures++; $display("FAIL stall_beat%0d got=%h exp=%h", k, beats[k], exp_beat(k));
      end
    end
    checks++; if (stab_bad || ovf) begin failures++; $display("FAIL stall_hold got=%b%b exp=00", stab_bad, ovf); end
  endtask

  task automatic test_back_to_back();
    time ts;
    clear_log();
    tready_s = 1'b1;
    pulse_start_s(ts);
    repeat (5) @(posedge clk);
    pulse_start_s(ts);
    wait_done_s(1, 200);
    repeat (30) @(negedge clk);
    checks++; if (done_t.size() != 1) begin failures++; $display("FAIL restart_ign_done got=%0d exp=1", done_t.size()); end
    checks++; if (beats.size() != 16) begin failures++; $display("FAIL restart_ign_beats got=%0d exp=16", beats.size()); end
    checks++; if (rd_cnt != 8) begin failures++; $display("FAIL restart_ign_reads got=%0d exp=8", rd_cnt); end
    clear_log();
    pulse_start_s(ts);
    for (int i = 0; i < 200 && done_s !== 1'b1; i++) @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    checks++; if (busy_s !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", busy_s); end
    wait_done_s(2, 200);
    repeat (20) @(negedge clk);
    checks++; if (done_t.size() != 2) begin failures++; $display("FAIL restart_done got=%0d exp=2", done_t.size()); end
    checks++; if (beats.size() != 32) begin failures++; $display("FAIL restart_beats got=%0d exp=32", beats.size()); end
    for (int k = 16; k < beats.size() && k < 32; k++) begin
      checks++;
      if (beats[k] !== exp_beat(k - 16)) begin
        failures++; $display("FAIL restart_beat%0d got=%h exp=%h", k, beats[k], exp_beat(k - 16));
      end
    end
  endtask

  task automatic test_reset_midframe();
    time ts;
    clear_log();
    tready_s = 1'b1;
    pulse_start_s(ts);
    for (int i = 0; i < 100 && beats.size() < 5; i++) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (tvalid_s !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", tvalid_s); end
    checks++; if (tlast_s !== 1'b0 || tdata_s !== 32'd0) begin
      failures++; $display("FAIL rst_tdata got=%h/%b exp=0/0", tdata_s, tlast_s);
    end
    checks++; if (busy_s !== 1'b0 || rd_en_s !== 1'b0) begin
      failures++; $display("FAIL rst_ctrl got=%b%b exp=00", busy_s, rd_en_s);
    end
    checks++; if (u_s.fifo_count !== 5'd0) begin failures++; $display("FAIL rst_fifo got=%0d exp=0", u_s.fifo_count); end
    checks++; if (done_t.size() != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_t.size()); end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
    pulse_start_s(ts);
    wait_done_s(1, 200);
    checks++; if (beats.size() != 16) begin failures++; $display("FAIL rst_new_cnt got=%0d exp=16", beats.size()); end
    for (int k = 0; k < beats.size() && k < 16; k++) begin
      checks++;
      if (beats[k] !== exp_beat(k)) begin
        failures++; $display("FAIL rst_new_beat%0d got=%h exp=%h", k, beats[k], exp_beat(k));
      end
    end
  endtask

  task automatic test_default_size();
    bd_cnt = 0; bd_err = 0; bd_done = 0;
    tready_d = 1'b1;
    @(posedge clk);
    #1 start_d = 1'b1;
    @(posedge clk);
    #1 start_d = 1'b0;
    for (int i = 0; i < 9000 && bd_done < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (bd_done != 1) begin failures++; $display("FAIL dflt_done got=%0d exp=1", bd_done); end
    checks++; if (bd_cnt != 8192) begin failures++; $display("FAIL dflt_beats got=%0d exp=8192", bd_cnt); end
    checks++; if (bd_err != 0) begin failures++; $display("FAIL dflt_data got=%0d exp=0", bd_err); end
    checks++; if (tvalid_d !== 1'b0 || busy_d !== 1'b0) begin
      failures++; $display("FAIL dflt_idle got=%b%b exp=00", tvalid_d, busy_d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_stall();
    test_stall();
    test_back_to_back();
    test_reset_midframe();
    test_default_size();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
